// File: rtl/nfc_pkg.sv
// Shared types and widths for the NFC ADC envelope path.
package nfc_pkg;

    localparam int ADC_W = 12;
    localparam logic [ADC_W-1:0] ADC_MID = 12'd2048;

    typedef logic [ADC_W-1:0] adc_t;

    // Width that holds win full-scale magnitudes without wrapping.
    function automatic int env_w(input int win);
        return ADC_W + $clog2(win + 1);
    endfunction

endpackage

// File: rtl/nfc_win_sum.sv
// Sliding-window sum of rectified samples: WIN-deep delay line, running sum and fill counter.
module nfc_win_sum
    import nfc_pkg::*;
#(
    parameter int WIN = 6,
    parameter int W   = env_w(WIN)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_en,
    input  adc_t         in_val,
    output logic         fire,
    output logic         out_en,
    output logic [W-1:0] out_sum
);

    localparam int CW = $clog2(WIN + 1);

    adc_t          line_p2 [WIN];
    logic [W-1:0]  sum_p2;
    logic [CW-1:0] fill_p2;
    logic [W-1:0]  sum_nxt;

    // Slots start cleared, so the tail reads 0 until the line has filled.
    assign sum_nxt = sum_p2 + W'(in_val) - W'(line_p2[WIN-1]);
    assign fire    = in_en && (fill_p2 >= CW'(WIN - 1));

    // ---- stage 2: window update and result register ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < WIN; i++) begin
                line_p2[i] <= '0;
            end
            sum_p2  <= '0;
            fill_p2 <= '0;
            out_en  <= 1'b0;
            out_sum <= '0;
        end else begin
            out_en <= fire;
            if (in_en) begin
                line_p2[0] <= in_val;
                for (int i = 1; i < WIN; i++) begin
                    line_p2[i] <= line_p2[i-1];
                end
                sum_p2 <= sum_nxt;
                if (fill_p2 != CW'(WIN)) begin
                    fill_p2 <= fill_p2 + CW'(1);
                end
            end
            if (fire) begin
                out_sum <= sum_nxt;
            end
        end
    end

endmodule

// File: rtl/nfc_adc_envelope.sv
// DC removal, rectification and windowed sum of the ADC stream for the NFC bit decoder.
// Define NFC_ENV_DETECT_EN to add the hysteretic o_load detector.
module nfc_adc_envelope
    import nfc_pkg::*;
#(
    parameter int WIN      = 6,
    parameter int DC_SHIFT = 6
`ifdef NFC_ENV_DETECT_EN
    ,
    parameter int TH_HI    = 2048,
    parameter int TH_LO    = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_en,
    input  adc_t                   i_data,
    output logic                   o_en,
    output adc_t                   o_dc,
    output logic [env_w(WIN)-1:0]  o_env
`ifdef NFC_ENV_DETECT_EN
    ,
    output logic                   o_load
`endif
);

    localparam int EW    = env_w(WIN);
    localparam int ACC_W = ADC_W + DC_SHIFT;
    localparam logic [ACC_W-1:0] ACC_INIT = ACC_W'(ADC_MID) << DC_SHIFT;

    // |v| for v in -4095..4095 always fits the unsigned sample width.
    function automatic adc_t abs13(input logic signed [ADC_W:0] v);
        return adc_t'((v < 0) ? -v : v);
    endfunction

    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_nxt;
    adc_t                    mean_p0;
    logic signed [ADC_W:0]   diff_p0;

    logic                    vld_p1;
    adc_t                    a_p1;
    adc_t                    dc_p1;

    logic                    fire;

    // ---- stage 0: IIR mean tracker, residual against the pre-update mean ----
    assign mean_p0 = acc[ACC_W-1:DC_SHIFT];
    assign diff_p0 = $signed({1'b0, i_data}) - $signed({1'b0, mean_p0});
    assign acc_nxt = acc + ACC_W'(i_data) - ACC_W'(mean_p0);

    // ---- stage 1: rectified residual and updated mean ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc    <= ACC_INIT;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= i_en;
            if (i_en) begin
                acc <= acc_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            a_p1  <= abs13(diff_p0);
            dc_p1 <= acc_nxt[ACC_W-1:DC_SHIFT];
        end
    end

    // ---- stage 2: window sum and output registers ----
    nfc_win_sum #(
        .WIN (WIN),
        .W   (EW)
    ) u_win_sum (
        .clk     (clk),
        .rstn    (rstn),
        .in_en   (vld_p1),
        .in_val  (a_p1),
        .fire    (fire),
        .out_en  (o_en),
        .out_sum (o_env)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_dc <= ADC_MID;
        end else if (fire) begin
            o_dc <= dc_p1;
        end
    end

`ifdef NFC_ENV_DETECT_EN
    logic load_q;

    // o_env only moves on o_en, so the decision is taken from it directly and latched on o_en.
    always_comb begin
        o_load = load_q;
        if (o_env >= EW'(TH_HI)) begin
            o_load = 1'b1;
        end else if (o_env < EW'(TH_LO)) begin
            o_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            load_q <= 1'b0;
        end else if (o_en) begin
            load_q <= o_load;
        end
    end
`endif

endmodule

// File: tb/tb_nfc_adc_envelope.sv
// Scoreboard bench for nfc_adc_envelope; checks o_load too when NFC_ENV_DETECT_EN is defined.
module tb_nfc_adc_envelope;
    import nfc_pkg::*;

    localparam int WIN      = 6;
    localparam int DC_SHIFT = 6;
    localparam int EW       = env_w(WIN);
    localparam int TH_HI    = 2048;
    localparam int TH_LO    = 1024;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          i_en = 1'b0;
    logic [11:0]   i_data = '0;
    logic          o_en;
    logic [11:0]   o_dc;
    logic [EW-1:0] o_env;
`ifdef NFC_ENV_DETECT_EN
    logic          o_load;
`endif

    always #5 clk = ~clk;

    nfc_adc_envelope #(
        .WIN      (WIN),
        .DC_SHIFT (DC_SHIFT)
`ifdef NFC_ENV_DETECT_EN
        ,
        .TH_HI    (TH_HI),
        .TH_LO    (TH_LO)
`endif
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (i_en),
        .i_data (i_data),
        .o_en   (o_en),
        .o_dc   (o_dc),
        .o_env  (o_env)
`ifdef NFC_ENV_DETECT_EN
        ,
        .o_load (o_load)
`endif
    );

    typedef struct {
        longint due;
        int     dc;
        int     env;
        bit     load;
    } exp_t;

    exp_t   sbq[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     n_oen = 0;
    longint cyc   = 0;

    int     macc;
    int     mwin[$];
    int     mcnt;
    bit     mload;

    int     rec = 0;
    int     seq_a[$];
    int     seq_b[$];
    bit     step_on = 1'b0;
    int     prev_dc = 2048;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        macc = 2048 << DC_SHIFT;
        mwin.delete();
        mcnt  = 0;
        mload = 1'b0;
    endtask

    // Issue one sample, predict its result from the behavioural model, then idle gap-1 cycles.
    task automatic send(input int d, input int gap);
        int   mean;
        int   a;
        int   env;
        exp_t e;
        @(posedge clk); #1;
        i_en   = 1'b1;
        i_data = 12'(d);
        mean = macc >> DC_SHIFT;
        a    = d - mean;
        if (a < 0) a = -a;
        macc = macc + d - mean;
        mwin.push_back(a);
        if (mwin.size() > WIN) void'(mwin.pop_front());
        mcnt++;
        if (mcnt >= WIN) begin
            env = 0;
            foreach (mwin[i]) env += mwin[i];
            if (env >= TH_HI) mload = 1'b1;
            else if (env < TH_LO) mload = 1'b0;
            e.due  = cyc + 2;
            e.dc   = macc >> DC_SHIFT;
            e.env  = env;
            e.load = mload;
            sbq.push_back(e);
        end
        for (int k = 1; k < gap; k++) begin
            @(posedge clk); #1;
            i_en = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            i_en = 1'b0;
        end
    endtask

    // One-cycle reset pulse; anything still in flight is expected to vanish.
    task automatic do_reset();
        exp_t keep[$];
        @(posedge clk); #1;
        rstn   = 1'b0;
        i_en   = 1'($urandom_range(0, 1));
        i_data = 12'($urandom_range(0, 4095));
        foreach (sbq[i]) if (sbq[i].due <= cyc) keep.push_back(sbq[i]);
        sbq = keep;
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        i_en = 1'b0;
        @(negedge clk);
        check("rst_o_en", o_en, 0);
        check("rst_o_dc", o_dc, 2048);
        check("rst_o_env", o_env, 0);
`ifdef NFC_ENV_DETECT_EN
        check("rst_o_load", o_load, 0);
`endif
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_en) begin
            n_oen++;
            if (sbq.size() == 0) begin
                check("spurious_o_en", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("o_en_latency", cyc, e.due);
                check("o_dc", o_dc, e.dc);
                check("o_env", o_env, e.env);
`ifdef NFC_ENV_DETECT_EN
                check("o_load", o_load, e.load);
`endif
            end
            check("env_bound", o_env <= WIN * 4095, 1);
            if (rec == 1) seq_a.push_back(int'(o_env));
            if (rec == 2) seq_b.push_back(int'(o_env));
            if (step_on) begin
                check("step_dc_monotonic", o_dc >= prev_dc, 1);
                check("step_dc_le_3000", o_dc <= 3000, 1);
                prev_dc = int'(o_dc);
            end
        end
    end

    initial begin
        int n0;
        model_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_o_en", o_en, 0);
        check("init_o_dc", o_dc, 2048);
        check("init_o_env", o_env, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Constant mid-scale, sparse strobes
        for (int i = 0; i < 8; i++) send(2048, 32);
        idle(4);

        // Alternating +-512 around mid-scale, back-to-back
        do_reset();
        n0 = n_oen;
        for (int i = 0; i < 250; i++) begin
            send(2560, 1);
            send(1536, 1);
        end
        idle(4);
        check("alt_oen_count", n_oen - n0, 500 - 5);
        check("alt_dc_near_mid", (o_dc >= 2048 - 16) && (o_dc <= 2048 + 16), 1);
        check("alt_env_near_3072", (o_env >= 3072 - 96) && (o_env <= 3072 + 96), 1);

        // Step 2048 -> 3000
        do_reset();
        prev_dc = 2048;
        step_on = 1'b1;
        for (int i = 0; i < 400; i++) send(3000, 1);
        idle(4);
        step_on = 1'b0;
        check("step_dc_reached", o_dc >= 2990, 1);

        // Random stream, then a reset with a sample in flight
        for (int i = 0; i < 40; i++) send(int'($urandom_range(1500, 2600)), int'($urandom_range(1, 3)));
        send(int'($urandom_range(0, 4095)), 1);
        do_reset();
        for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 4095)), int'($urandom_range(1, 2)));
        idle(4);

        // Envelope ramp up, hold mid, fall low
        do_reset();
        for (int amp = 0; amp <= 500; amp += 20) begin
            send(2048 + amp, 1);
            send(2048 - amp, 1);
        end
        for (int i = 0; i < 30; i++) begin
            send(2048 + 250, 1);
            send(2048 - 250, 1);
        end
        for (int i = 0; i < 30; i++) begin
            send(2048 + 150, 1);
            send(2048 - 150, 1);
        end
        idle(4);

        // Full-scale alternation: gap-free vs 32-cycle spacing
        do_reset();
        rec = 1;
        for (int i = 0; i < 12; i++) begin
            send(0, 1);
            send(4095, 1);
        end
        idle(4);
        rec = 0;
        do_reset();
        rec = 2;
        for (int i = 0; i < 12; i++) begin
            send(0, 32);
            send(4095, 32);
        end
        idle(4);
        rec = 0;
        check("seq_len", seq_b.size(), seq_a.size());
        for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++) check("seq_env", seq_b[i], seq_a[i]);

        // Random full-range data with random spacing
        for (int i = 0; i < 200; i++) send(int'($urandom_range(0, 4095)), int'($urandom_range(1, 3)));
        idle(6);
        check("scoreboard_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
